apb_req_arbiter: RTL and testbench



---
 rtl/apb_req_arbiter_pkg.sv | 21 ++
 rtl/apb_req_arbiter_if.sv | 42 ++++
 rtl/apb_req_arbiter_rr_arbiter.sv | 31 +++
 rtl/apb_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and constants for the APB request arbiter.
//   apb_state_t : transfer FSM encoding (IDLE, SETUP, ACCESS)
//   APB_*_WIDTH : default bus widths
//   rsp_t       : response record (read data + error flag)
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

    localparam int unsigned APB_ADDR_WIDTH = 4;
    localparam int unsigned APB_DATA_WIDTH = 8;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } rsp_t;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Bundle of requester-side handshake signals and APB bus signals.
//   master : view of the arbiter (drives req_ready, rsp_*, APB master outputs)
//   slave  : view of the environment (requesters + APB slave)
// Requester i owns slice i of the packed req_addr / req_wdata vectors.
interface apb_req_arbiter_if
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;

    logic [ADDR_WIDTH-1:0]         PADDAR;
    logic                          PSLEx;
    logic                          PENABLE;
    logic                          PWRITE;
    logic [DATA_WIDTH-1:0]         PWDATA;
    logic                          PREADY;
    logic                          PSLVERR;
    logic [DATA_WIDTH-1:0]         PRDATA;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PREADY, PSLVERR, PRDATA,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               PADDAR, PSLEx, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PREADY, PSLVERR, PRDATA,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               PADDAR, PSLEx, PENABLE, PWRITE, PWDATA
    );

endinterface

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// Combinational round-robin selector.
//   req   : request vector
//   ptr   : highest-priority index (must be < NUM_REQ)
//   grant : one-hot winner (first set bit at or after ptr, wrapping)
//   idx   : binary index of the winner
//   any   : at least one request present
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            if (!any && req[IDX_W'((32'(ptr) + off) % NUM_REQ)]) begin
                any        = 1'b1;
                idx        = IDX_W'((32'(ptr) + off) % NUM_REQ);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// APB master shared by NUM_REQ requesters.
//   PCLK, RESETn : clock, asynchronous active-low reset
//   bus          : requester handshake (req_*, rsp_*) and APB master signals
// One IDLE->SETUP->ACCESS transfer per grant; a stalled ACCESS is aborted with
// an error response after TIMEOUT cycles without PREADY.
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 15
) (
    input logic               PCLK,
    input logic               RESETn,
    apb_req_arbiter_if.master bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    apb_state_t            state, state_nxt;
    logic [IDX_W-1:0]      ptr, ptr_nxt;
    logic [IDX_W-1:0]      owner, owner_nxt;
    logic [7:0]            cnt, cnt_nxt, cnt_inc;
    logic                  psel_q, psel_nxt;
    logic                  pen_q, pen_nxt;
    logic                  pwrite_q, pwrite_nxt;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_nxt;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_nxt;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_nxt;
    logic                  err_q, err_nxt;
    logic [NUM_REQ-1:0]    rspv_q, rspv_nxt;

    logic [NUM_REQ-1:0]    grant;
    logic [IDX_W-1:0]      win;
    logic                  any;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win),
        .any   (any)
    );

    assign cnt_inc = cnt + 8'd1;

    assign bus.req_ready = (state == IDLE) ? grant : '0;
    assign bus.rsp_valid = rspv_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.PADDAR    = paddr_q;
    assign bus.PSLEx     = psel_q;
    assign bus.PENABLE   = pen_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;

    // Next values of every register; rsp_valid defaults low so it pulses.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        owner_nxt  = owner;
        cnt_nxt    = cnt;
        psel_nxt   = psel_q;
        pen_nxt    = pen_q;
        pwrite_nxt = pwrite_q;
        paddr_nxt  = paddr_q;
        pwdata_nxt = pwdata_q;
        rdata_nxt  = rdata_q;
        err_nxt    = err_q;
        rspv_nxt   = '0;
        case (state)
            IDLE: begin
                if (any) begin
                    paddr_nxt  = bus.req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                    pwdata_nxt = bus.req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
                    pwrite_nxt = bus.req_write[win];
                    psel_nxt   = 1'b1;
                    owner_nxt  = win;
                    ptr_nxt    = (32'(win) == NUM_REQ - 1) ? '0 : win + IDX_W'(1);
                    state_nxt  = SETUP;
                end
            end
            SETUP: begin
                pen_nxt   = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rspv_nxt[owner] = 1'b1;
                    if (!pwrite_q) begin
                        rdata_nxt = bus.PRDATA;
                    end
                    err_nxt   = bus.PSLVERR;
                    psel_nxt  = 1'b0;
                    pen_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else if (cnt_inc == 8'(TIMEOUT)) begin
                    // Abort: error response, read data left untouched.
                    rspv_nxt[owner] = 1'b1;
                    err_nxt   = 1'b1;
                    psel_nxt  = 1'b0;
                    pen_nxt   = 1'b0;
                    cnt_nxt   = cnt_inc;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            cnt      <= '0;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rspv_q   <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            cnt      <= cnt_nxt;
            psel_q   <= psel_nxt;
            pen_q    <= pen_nxt;
            pwrite_q <= pwrite_nxt;
            paddr_q  <= paddr_nxt;
            pwdata_q <= pwdata_nxt;
            rdata_q  <= rdata_nxt;
            err_q    <= err_nxt;
            rspv_q   <= rspv_nxt;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: bench-side APB memory slave with
// configurable wait states / hang / error, and a reference model holding the
// round-robin pointer, memory contents and last read data.
module tb_apb_req_arbiter;
    import apb_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 15;

    logic PCLK   = 1'b0;
    logic RESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_req_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK   (PCLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- APB slave (environment) ----------------
    logic [DW-1:0] slv_mem [16] = '{default: 8'h00};
    int  slave_wait = 0;
    bit  slave_hang = 1'b0;
    bit  slave_err  = 1'b0;
    int  acc_cnt    = 0;

    always @(negedge PCLK) begin
        if (bus.PSLEx && bus.PENABLE) begin
            bus.PREADY  = !slave_hang && (acc_cnt >= slave_wait);
            bus.PSLVERR = bus.PREADY && slave_err;
            bus.PRDATA  = slv_mem[bus.PADDAR];
            acc_cnt++;
        end else begin
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b0;
            bus.PRDATA  = '0;
            acc_cnt     = 0;
        end
    end

    always @(posedge PCLK) begin
        if (RESETn && bus.PSLEx && bus.PENABLE && bus.PREADY && bus.PWRITE && !bus.PSLVERR)
            slv_mem[bus.PADDAR] <= bus.PWDATA;
    end

    // ---------------- Reference model ----------------
    int            m_ptr = 0;
    logic [DW-1:0] mem_model [16] = '{default: 8'h00};
    logic [DW-1:0] m_rdata = '0;

    function automatic int model_pick(input logic [NR-1:0] mask);
        for (int k = 0; k < int'(NR); k++) begin
            if (((mask >> ((m_ptr + k) % NR)) & NR'(1)) != '0) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    typedef struct {
        logic [NR-1:0] gnt;
        int            gwait;
        logic          s_psel, s_pen, a_pen;
        logic [AW-1:0] addr1;
        logic          w1;
        logic [DW-1:0] wd1;
        logic [NR-1:0] s_rspv;
        bit            stable;
        int            lat;
        logic [NR-1:0] rspv;
        logic [DW-1:0] rdata;
        logic          err;
        bit            lost;
    } obs_t;

    task automatic tick();
        @(negedge PCLK);
        #1;
    endtask

    task automatic set_req(input int r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [NR-1:0] bit_r;
        bit_r = NR'(1) << r;
        bus.req_write = (bus.req_write & ~bit_r) | (w ? bit_r : '0);
        bus.req_addr  = (bus.req_addr & ~((NR*AW)'({AW{1'b1}}) << (r*AW))) | ((NR*AW)'(a) << (r*AW));
        bus.req_wdata = (bus.req_wdata & ~((NR*DW)'({DW{1'b1}}) << (r*DW))) | ((NR*DW)'(d) << (r*DW));
        bus.req_valid = bus.req_valid | bit_r;
    endtask

    // Observe one transfer: grant, SETUP/ACCESS phases, response. Cycle counts
    // are relative to the grant cycle.
    task automatic xfer(input bit drop, output obs_t o);
        o = '{default: '0};
        o.stable = 1'b1;
        #1;
        while (bus.req_ready == '0 && o.gwait < 20) begin
            tick();
            o.gwait++;
        end
        o.gnt = bus.req_ready;
        if (o.gnt == '0) begin
            o.lost = 1'b1;
            return;
        end
        tick();
        o.lat = 1;
        if (drop) bus.req_valid = '0;
        o.s_psel = bus.PSLEx;
        o.s_pen  = bus.PENABLE;
        o.addr1  = bus.PADDAR;
        o.w1     = bus.PWRITE;
        o.wd1    = bus.PWDATA;
        o.s_rspv = bus.rsp_valid;
        tick();
        o.lat   = 2;
        o.a_pen = bus.PENABLE;
        while (bus.rsp_valid == '0 && o.lat < 40) begin
            if (bus.PADDAR !== o.addr1 || bus.PWRITE !== o.w1 || bus.PWDATA !== o.wd1)
                o.stable = 1'b0;
            tick();
            o.lat++;
        end
        o.rspv  = bus.rsp_valid;
        o.rdata = bus.rsp_rdata;
        o.err   = bus.rsp_err;
        if (o.rspv == '0) o.lost = 1'b1;
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        RESETn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.PSLEx, bus.PENABLE, bus.PWRITE} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000", {bus.PSLEx, bus.PENABLE, bus.PWRITE});
        end
        checks++;
        if (bus.PADDAR !== '0 || bus.PWDATA !== '0) begin
            errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", bus.PADDAR, bus.PWDATA);
        end
        checks++;
        if (bus.rsp_valid !== '0 || bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp: got %b/%h/%b want 0/0/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        RESETn = 1'b1;
        m_ptr = 0;
        m_rdata = '0;
        tick();
        checks++;
        if (bus.req_ready !== '0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", bus.req_ready);
        end
    endtask

    task automatic test_write_read();
        obs_t o;
        int   w;
        set_req(0, 1'b1, 4'h3, 8'hA5);
        w = model_pick(bus.req_valid);
        xfer(1'b1, o);
        checks++;
        if (o.lost || o.gnt !== NR'(1) << w) begin
            errors++; $display("FAIL wr_grant: got %b want %b", o.gnt, NR'(1) << w);
        end
        checks++;
        if ({o.s_psel, o.s_pen, o.a_pen} !== 3'b101) begin
            errors++; $display("FAIL wr_phases: psel/pen n+1, pen n+2 got %b want 101", {o.s_psel, o.s_pen, o.a_pen});
        end
        checks++;
        if (o.addr1 !== 4'h3 || o.w1 !== 1'b1 || o.wd1 !== 8'hA5) begin
            errors++; $display("FAIL wr_latch: got %h/%b/%h want 3/1/a5", o.addr1, o.w1, o.wd1);
        end
        checks++;
        if (o.lat != 3 || o.rspv !== NR'(1) << w || o.err !== 1'b0 || o.rdata !== m_rdata || o.s_rspv !== '0) begin
            errors++; $display("FAIL wr_rsp: lat %0d rspv %b err %b rdata %h want 3/%b/0/%h", o.lat, o.rspv, o.err, o.rdata, NR'(1) << w, m_rdata);
        end
        mem_model[3] = 8'hA5;
        m_ptr = (w + 1) % NR;

        set_req(0, 1'b0, 4'h3, 8'h00);
        w = model_pick(bus.req_valid);
        xfer(1'b1, o);
        m_rdata = mem_model[3];
        checks++;
        if (o.lost || o.gnt !== NR'(1) << w || o.lat != 3 || o.rdata !== m_rdata || o.err !== 1'b0) begin
            errors++; $display("FAIL rd_rsp: gnt %b lat %0d rdata %h err %b want %b/3/%h/0", o.gnt, o.lat, o.rdata, o.err, NR'(1) << w, m_rdata);
        end
        m_ptr = (w + 1) % NR;
        tick();
        checks++;
        if (bus.rsp_valid !== '0) begin
            errors++; $display("FAIL rd_pulse: rsp_valid got %b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_contention();
        obs_t o;
        int   w;
        logic [DW-1:0] exp_rd;
        set_req(0, 1'b1, 4'h5, 8'h11);
        set_req(1, 1'b0, 4'h5, 8'h00);
        for (int k = 0; k < 4; k++) begin
            w = model_pick(2'b11);
            xfer(1'b0, o);
            if (w == 0) mem_model[5] = 8'h11;
            else m_rdata = mem_model[5];
            exp_rd = m_rdata;
            checks++;
            if (o.lost || o.gnt !== NR'(1) << w || o.rspv !== NR'(1) << w) begin
                errors++; $display("FAIL cont_order[%0d]: gnt %b rspv %b want %b", k, o.gnt, o.rspv, NR'(1) << w);
            end
            checks++;
            if (o.lat != 3 || (k > 0 && o.gwait != 0) || o.rdata !== exp_rd) begin
                errors++; $display("FAIL cont_timing[%0d]: lat %0d gwait %0d rdata %h want 3/0/%h", k, o.lat, o.gwait, o.rdata, exp_rd);
            end
            m_ptr = (w + 1) % NR;
        end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_wait_states();
        obs_t o;
        int   w;
        slave_wait = 4;
        set_req(1, 1'b0, 4'h3, 8'h00);
        w = model_pick(bus.req_valid);
        xfer(1'b1, o);
        m_rdata = mem_model[3];
        checks++;
        if (o.lost || o.lat != 7 || !o.stable || o.rspv !== NR'(1) << w || o.rdata !== m_rdata) begin
            errors++; $display("FAIL wait4: lat %0d stable %b rspv %b rdata %h want 7/1/%b/%h", o.lat, o.stable, o.rspv, o.rdata, NR'(1) << w, m_rdata);
        end
        m_ptr = (w + 1) % NR;
        slave_wait = 0;
    endtask

    task automatic test_timeout();
        obs_t o;
        int   w;
        slave_hang = 1'b1;
        set_req(0, 1'b0, 4'h5, 8'h00);
        w = model_pick(bus.req_valid);
        xfer(1'b1, o);
        checks++;
        if (o.lost || o.lat != int'(TO) + 2 || o.err !== 1'b1 || o.rspv !== NR'(1) << w || o.rdata !== m_rdata) begin
            errors++; $display("FAIL timeout: lat %0d err %b rspv %b rdata %h want %0d/1/%b/%h", o.lat, o.err, o.rspv, o.rdata, TO + 2, NR'(1) << w, m_rdata);
        end
        m_ptr = (w + 1) % NR;
        slave_hang = 1'b0;
        tick();
        checks++;
        if (bus.rsp_valid !== '0 || bus.PSLEx !== 1'b0) begin
            errors++; $display("FAIL timeout_idle: rsp_valid %b psel %b want 0/0", bus.rsp_valid, bus.PSLEx);
        end
        set_req(0, 1'b1, 4'h9, 8'h3C);
        w = model_pick(bus.req_valid);
        xfer(1'b1, o);
        mem_model[9] = 8'h3C;
        checks++;
        if (o.lost || o.lat != 3 || o.err !== 1'b0 || o.rspv !== NR'(1) << w) begin
            errors++; $display("FAIL after_timeout: lat %0d err %b rspv %b want 3/0/%b", o.lat, o.err, o.rspv, NR'(1) << w);
        end
        m_ptr = (w + 1) % NR;
    endtask

    task automatic test_pslverr();
        obs_t o;
        int   w;
        slave_err = 1'b1;
        set_req(1, 1'b0, 4'h9, 8'h00);
        w = model_pick(bus.req_valid);
        xfer(1'b1, o);
        m_rdata = mem_model[9];
        checks++;
        if (o.lost || o.err !== 1'b1 || o.rspv !== NR'(1) << w || o.rdata !== m_rdata || o.lat != 3) begin
            errors++; $display("FAIL pslverr: err %b rspv %b rdata %h lat %0d want 1/%b/%h/3", o.err, o.rspv, o.rdata, o.lat, NR'(1) << w, m_rdata);
        end
        m_ptr = (w + 1) % NR;
        slave_err = 1'b0;
        tick();
        checks++;
        if (bus.rsp_valid !== '0) begin
            errors++; $display("FAIL pslverr_pulse: rsp_valid got %b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_random();
        obs_t          o;
        int            w;
        logic [NR-1:0] mask;
        logic          fw [NR];
        logic [AW-1:0] fa [NR];
        logic [DW-1:0] fd [NR];
        logic [DW-1:0] exp_rd;
        for (int it = 0; it < 24; it++) begin
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int r = 0; r < int'(NR); r++) begin
                fw[r] = 1'($urandom_range(0, 1));
                fa[r] = AW'($urandom);
                fd[r] = DW'($urandom);
                if (((mask >> r) & NR'(1)) != '0) set_req(r, fw[r], fa[r], fd[r]);
            end
            slave_wait = $urandom_range(0, 3);
            w = model_pick(mask);
            xfer(1'b1, o);
            if (fw[w]) mem_model[fa[w]] = fd[w];
            else m_rdata = mem_model[fa[w]];
            exp_rd = m_rdata;
            checks++;
            if (o.lost || o.gnt !== NR'(1) << w || o.addr1 !== fa[w] || o.w1 !== fw[w] || o.wd1 !== fd[w]) begin
                errors++; $display("FAIL rnd_grant[%0d]: gnt %b addr %h w %b wd %h want %b/%h/%b/%h", it, o.gnt, o.addr1, o.w1, o.wd1, NR'(1) << w, fa[w], fw[w], fd[w]);
            end
            checks++;
            if (o.lat != 3 + slave_wait || !o.stable || o.rspv !== NR'(1) << w || o.err !== 1'b0 || o.rdata !== exp_rd) begin
                errors++; $display("FAIL rnd_rsp[%0d]: lat %0d stable %b rspv %b err %b rdata %h want %0d/1/%b/0/%h", it, o.lat, o.stable, o.rspv, o.err, o.rdata, 3 + slave_wait, NR'(1) << w, exp_rd);
            end
            m_ptr = (w + 1) % NR;
        end
        slave_wait = 0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   n;
        slave_hang = 1'b1;
        set_req(0, 1'b0, 4'h3, 8'h00);
        #1;
        n = 0;
        while (bus.req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        repeat (3) tick();
        bus.req_valid = '0;
        checks++;
        if (bus.PENABLE !== 1'b1) begin
            errors++; $display("FAIL rstmid_access: PENABLE got %b want 1", bus.PENABLE);
        end
        RESETn = 1'b0;
        #1;
        checks++;
        if (bus.PSLEx !== 1'b0 || bus.PENABLE !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: psel %b pen %b want 0/0", bus.PSLEx, bus.PENABLE);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.rsp_valid !== '0 || bus.rsp_rdata !== '0) begin
                errors++; $display("FAIL rstmid_norsp[%0d]: rsp_valid %b rdata %h want 0/0", k, bus.rsp_valid, bus.rsp_rdata);
            end
        end
        RESETn = 1'b1;
        slave_hang = 1'b0;
        m_ptr = 0;
        m_rdata = '0;
        tick();
        set_req(0, 1'b0, 4'h9, 8'h00);
        set_req(1, 1'b0, 4'h3, 8'h00);
        xfer(1'b1, o);
        m_rdata = mem_model[9];
        checks++;
        if (o.lost || o.gnt !== NR'(1) || o.rspv !== NR'(1) || o.rdata !== m_rdata) begin
            errors++; $display("FAIL rstmid_next: gnt %b rspv %b rdata %h want 01/01/%h", o.gnt, o.rspv, o.rdata, m_rdata);
        end
        m_ptr = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_write_read();
        test_contention();
        test_wait_states();
        test_timeout();
        test_pslverr();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
